// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl: skips pipeline-fill samples, then drives the result memory write port for a programmed word count.
module rx_capture_ctrl #(
  parameter int PARAM_SKIP = 3
) (
  input  logic        MEM_CLK,
  input  logic        MEM_RESET,
  input  logic        CAP_START,
  input  logic        CAP_ABORT,
  input  logic [9:0]  CAP_LEN,
  input  logic        RES_VALID,
  input  logic [31:0] RES_DATA,
  output logic [8:0]  MEM_ADDR,
  output logic        MEM_WREN,
  output logic [31:0] MEM_DATA,
  output logic        CAP_BUSY,
  output logic        CAP_DONE,
  output logic [9:0]  CAP_COUNT,
  output logic [15:0] CAP_DROPPED
);
  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;
  state_t r_state, w_next;
  logic [9:0] r_len, w_len;
  logic [3:0] r_skip;
  logic w_start, w_fin, w_wr, w_drop, w_skip_last;
  assign w_len = CAP_LEN > 10'd512 ? 10'd512 : CAP_LEN;
  assign w_start = CAP_START && !CAP_ABORT && (r_state == IDLE || r_state == DONE);
  // Final word already written; DONE is entered on the following edge so BUSY/DONE trail the last write.
  assign w_fin = r_state == CAPTURE && CAP_COUNT == r_len;
  assign w_wr = r_state == CAPTURE && !w_fin && RES_VALID && !CAP_ABORT;
  assign w_drop = ((r_state == DONE && !w_start) || w_fin) && RES_VALID && !CAP_ABORT;
  assign w_skip_last = r_skip == 4'(PARAM_SKIP - 1);
  always_ff @(posedge MEM_CLK or posedge MEM_RESET)
    if (MEM_RESET) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (CAP_ABORT) w_next = IDLE;
    else if (w_start) w_next = w_len == 10'd0 ? DONE : PARAM_SKIP > 0 ? SKIP : CAPTURE;
    else if (r_state == SKIP && RES_VALID && w_skip_last) w_next = CAPTURE;
    else if (w_fin) w_next = DONE;
  end
  always_ff @(posedge MEM_CLK or posedge MEM_RESET)
    if (MEM_RESET) begin
      MEM_ADDR <= '0;
      MEM_WREN <= 1'b0;
      MEM_DATA <= '0;
      CAP_BUSY <= 1'b0;
      CAP_DONE <= 1'b0;
      CAP_COUNT <= '0;
      CAP_DROPPED <= '0;
      r_len <= '0;
      r_skip <= '0;
    end else begin
      MEM_WREN <= w_wr;
      CAP_BUSY <= w_next == SKIP || w_next == CAPTURE;
      CAP_DONE <= w_next == DONE;
      if (w_start) begin
        r_len <= w_len;
        r_skip <= '0;
        CAP_COUNT <= '0;
        CAP_DROPPED <= '0;
      end
      if (r_state == SKIP && RES_VALID && !CAP_ABORT) r_skip <= r_skip + 4'd1;
      if (w_wr) begin
        MEM_ADDR <= CAP_COUNT[8:0];
        MEM_DATA <= RES_DATA;
        CAP_COUNT <= CAP_COUNT + 10'd1;
      end
      if (w_drop && CAP_DROPPED != 16'hFFFF) CAP_DROPPED <= CAP_DROPPED + 16'd1;
    end
endmodule

// File: tb/tb_rx_capture_ctrl.sv
// tb_rx_capture_ctrl: directed and random stimulus checked cycle by cycle against a transaction-level capture model.
module tb_rx_capture_ctrl;
  localparam int SKIP = 3;
  logic        MEM_CLK = 1'b0;
  logic        MEM_RESET = 1'b1;
  logic        CAP_START = 1'b0;
  logic        CAP_ABORT = 1'b0;
  logic [9:0]  CAP_LEN = '0;
  logic        RES_VALID = 1'b0;
  logic [31:0] RES_DATA = '0;
  logic [8:0]  MEM_ADDR;
  logic        MEM_WREN;
  logic [31:0] MEM_DATA;
  logic        CAP_BUSY;
  logic        CAP_DONE;
  logic [9:0]  CAP_COUNT;
  logic [15:0] CAP_DROPPED;
  int n_chk = 0;
  int n_fail = 0;
  bit m_active, m_done, m_wren;
  int m_len, m_count, m_dropped, m_skip_left, m_addr;
  logic [31:0] m_data;

  rx_capture_ctrl #(.PARAM_SKIP(SKIP)) dut (
    .MEM_CLK(MEM_CLK), .MEM_RESET(MEM_RESET), .CAP_START(CAP_START), .CAP_ABORT(CAP_ABORT),
    .CAP_LEN(CAP_LEN), .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .MEM_ADDR(MEM_ADDR),
    .MEM_WREN(MEM_WREN), .MEM_DATA(MEM_DATA), .CAP_BUSY(CAP_BUSY), .CAP_DONE(CAP_DONE),
    .CAP_COUNT(CAP_COUNT), .CAP_DROPPED(CAP_DROPPED)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("wren", {31'd0, MEM_WREN}, {31'd0, m_wren});
    chk("addr", {23'd0, MEM_ADDR}, m_addr);
    chk("data", MEM_DATA, m_data);
    chk("busy", {31'd0, CAP_BUSY}, {31'd0, m_active});
    chk("done", {31'd0, CAP_DONE}, {31'd0, m_done});
    chk("count", {22'd0, CAP_COUNT}, m_count);
    chk("dropped", {16'd0, CAP_DROPPED}, m_dropped);
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_wren = 0;
    m_len = 0; m_count = 0; m_dropped = 0; m_skip_left = 0; m_addr = 0; m_data = '0;
  endtask

  // One clock edge of the capture transaction: a capture is "active" from an accepted start until the
  // edge after its last word, when it becomes "done".
  task automatic model_step(input bit st, input bit ab, input int ln, input bit v, input logic [31:0] d);
    m_wren = 0;
    if (ab) begin
      m_active = 0; m_done = 0;
    end else if (st && !m_active) begin
      m_len = ln > 512 ? 512 : ln;
      m_count = 0; m_dropped = 0; m_skip_left = SKIP;
      m_active = m_len != 0;
      m_done = m_len == 0;
    end else if (m_active) begin
      if (m_count == m_len) begin
        m_active = 0; m_done = 1;
        if (v) m_dropped++;
      end else if (v) begin
        if (m_skip_left > 0) m_skip_left--;
        else begin
          m_wren = 1; m_addr = m_count; m_data = d; m_count++;
        end
      end
    end else if (m_done && v && m_dropped < 65535) m_dropped++;
  endtask

  task automatic cycle(input bit st, input bit ab, input int ln, input bit v, input logic [31:0] d);
    @(negedge MEM_CLK);
    CAP_START = st; CAP_ABORT = ab; CAP_LEN = ln[9:0]; RES_VALID = v; RES_DATA = d;
    @(posedge MEM_CLK);
    model_step(st, ab, ln, v, d);
    #2;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'hDEAD0000 + i);
  endtask

  initial begin
    model_reset();
    #1;
    chk_all();
    @(negedge MEM_CLK);
    MEM_RESET = 1'b0;
    idle(2);
    cycle(0, 0, 0, 1, 32'h55);
    // basic capture: 11 back-to-back valids, first 3 skipped
    cycle(1, 0, 8, 0, 0);
    for (int i = 0; i <= 10; i++) cycle(0, 0, 0, 1, i);
    idle(1);
    chk("basic_done", {31'd0, CAP_DONE}, 32'd1);
    chk("basic_count", {22'd0, CAP_COUNT}, 32'd8);
    chk("basic_last", MEM_DATA, 32'd10);
    idle(2);
    // gapped stream with overrun
    cycle(1, 0, 4, 0, 0);
    for (int i = 0; i < 13; i++) begin
      cycle(0, 0, 0, 1, 32'h100 + i);
      idle(1);
    end
    chk("gap_dropped", {16'd0, CAP_DROPPED}, 32'd6);
    chk("gap_addr", {23'd0, MEM_ADDR}, 32'd3);
    // full-depth and clamped lengths
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, k == 0 ? 512 : 700, 0, 0);
      for (int i = 0; i < 515; i++) cycle(0, 0, 0, 1, i);
      idle(2);
      chk("max_count", {22'd0, CAP_COUNT}, 32'd512);
      chk("max_addr", {23'd0, MEM_ADDR}, 32'd511);
      chk("max_data", MEM_DATA, 32'd514);
    end
    // zero length completes immediately
    cycle(1, 0, 0, 0, 0);
    chk("len0_done", {31'd0, CAP_DONE}, 32'd1);
    cycle(0, 0, 0, 1, 7);
    idle(1);
    // abort mid-capture then restart
    cycle(1, 0, 10, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 32'h200 + i);
    cycle(0, 1, 0, 1, 32'h2FF);
    chk("abort_busy", {31'd0, CAP_BUSY}, 32'd0);
    chk("abort_done", {31'd0, CAP_DONE}, 32'd0);
    chk("abort_count", {22'd0, CAP_COUNT}, 32'd5);
    chk("abort_wren", {31'd0, MEM_WREN}, 32'd0);
    cycle(1, 0, 2, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h300 + i);
    idle(2);
    chk("restart_count", {22'd0, CAP_COUNT}, 32'd2);
    // start+abort together, start during capture, valid coincident with start
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 5, 0, 0);
    chk("startabort_busy", {31'd0, CAP_BUSY}, 32'd0);
    cycle(1, 0, 6, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h400 + i);
    cycle(1, 0, 3, 1, 32'h4AA);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h410 + i);
    chk("ign_start_count", {22'd0, CAP_COUNT}, 32'd6);
    cycle(1, 0, 2, 1, 32'h99);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 32'h500 + i);
    // asynchronous reset between edges while a write is on the port
    cycle(1, 0, 20, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 32'h600 + i);
    chk("pre_reset_wren", {31'd0, MEM_WREN}, 32'd1);
    #1 MEM_RESET = 1'b1;
    #1;
    model_reset();
    chk_all();
    @(negedge MEM_CLK);
    MEM_RESET = 1'b0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 32'h700 + i);
    cycle(1, 0, 3, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 32'h800 + i);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      automatic bit st = $urandom_range(0, 24) == 0;
      automatic bit ab = $urandom_range(0, 79) == 0;
      automatic int ln = $urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 12);
      cycle(st, ab, ln, $urandom_range(0, 9) < 7, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
